// File: rtl/regfile_reader.sv
// Burst reader: turns (addr, len) commands into a stream of regfile read beats.
// Latency: first out_valid one cycle after acceptance, then one beat per cycle; done one cycle after the last handshake.
// Backpressure: a full output register with out_ready low holds out_data/out_last/raddr and stops loading.
// Optional feature macro: REGFILE_READER_SUM_EN adds a running modulo sum of the handshaked beats.
module regfile_reader #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DEPTH-1:0] cmd_addr,
  input  logic [DEPTH:0]   cmd_len,
  output logic [DEPTH-1:0] raddr,
  input  logic [WIDTH-1:0] rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
`ifdef REGFILE_READER_SUM_EN
  output logic [WIDTH-1:0] sum,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [DEPTH-1:0] LP_ADDR_ONE = {{(DEPTH-1){1'b0}}, 1'b1};
  localparam logic [DEPTH:0]   LP_LEN_ONE  = {{DEPTH{1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DEPTH-1:0] r_addr;
  logic [DEPTH:0]   r_remaining;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic             r_done;

  logic             w_accept;
  logic             w_len_zero;
  logic             w_rem_one;
  logic             w_load;
  logic             w_flush_done;
  logic             w_done_nxt;

  assign w_len_zero = (cmd_len == '0);
  assign w_rem_one  = (r_remaining == LP_LEN_ONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the load/accept/complete strobes used by the datapath.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_flush_done = 1'b0;
    w_done_nxt   = 1'b0;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_accept = 1'b1;
          if (w_len_zero) begin
            // Empty burst completes immediately: no beats, just the done pulse.
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        // Output register can take a new beat when empty or being drained this cycle.
        if (!r_out_valid || out_ready) begin
          w_load = 1'b1;
          if (w_rem_one) begin
            w_state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // The register holds the last beat; its handshake ends the burst.
        if (r_out_valid && out_ready) begin
          w_flush_done = 1'b1;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Address/length counters, output beat register and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_accept && !w_len_zero) begin
        r_addr      <= cmd_addr;
        r_remaining <= cmd_len;
      end
      if (w_load) begin
        r_out_data  <= rdata;
        r_out_valid <= 1'b1;
        r_out_last  <= w_rem_one;
        // Natural overflow of the DEPTH-bit register gives the modulo wrap.
        r_addr      <= r_addr + LP_ADDR_ONE;
        r_remaining <= r_remaining - LP_LEN_ONE;
      end
      if (w_flush_done) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

`ifdef REGFILE_READER_SUM_EN
  logic [WIDTH-1:0] r_sum;

  // Running sum of handshaked beats; cleared on acceptance so it holds from done to the next command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= '0;
    end else if (r_out_valid && out_ready) begin
      r_sum <= r_sum + r_out_data;
    end
  end

  assign sum = r_sum;
`endif

  assign raddr     = r_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign done      = r_done;

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader with a behavioural 256x16 regfile.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// Expected values are hand-computed constants per scenario.
module tb_regfile_reader;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [8:0]  cmd_len;
  logic [7:0]  raddr;
  logic [15:0] rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef REGFILE_READER_SUM_EN
  logic [15:0] sum;
`endif

  logic [15:0] mem [0:255];

  int n_checks;
  int n_errors;

  logic [15:0] got_q[$];
  logic        got_last_q[$];
  int          done_cnt;
  int          done_cyc;
  int          first_vld_cyc;
  int          rdy_low_cnt;
  logic [15:0] sum_at_done;

  regfile_reader #(.DEPTH(8), .WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .raddr     (raddr),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
`ifdef REGFILE_READER_SUM_EN
    .sum       (sum),
`endif
    .done      (done)
  );

  assign rdata = mem[raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Call at 1ns after an edge while idle; returns 1ns after the acceptance edge.
  task automatic issue(input logic [7:0] a, input logic [8:0] l);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Observe the output stream for up to 'budget' cycles; cycle 0 is right after acceptance.
  task automatic collect(input int budget, input bit stall);
    logic [15:0] prev_d;
    logic        prev_l;
    logic        prev_stall;
    got_q.delete();
    got_last_q.delete();
    done_cnt      = 0;
    done_cyc      = -1;
    first_vld_cyc = -1;
    rdy_low_cnt   = 0;
    sum_at_done   = '0;
    prev_stall    = 1'b0;
    prev_d        = '0;
    prev_l        = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (!cmd_ready) rdy_low_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
`ifdef REGFILE_READER_SUM_EN
        sum_at_done = sum;
`endif
      end
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (prev_stall) begin
        check("stall_data_hold", {16'h0, out_data}, {16'h0, prev_d});
        check("stall_last_hold", {31'h0, out_last}, {31'h0, prev_l});
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_last_q.push_back(out_last);
      end
      if (done_cnt > 0 && cyc > done_cyc + 2) break;
      @(posedge clk); #1;
    end
  endtask

  // Common checks for the four-beat burst at address 5.
  task automatic check_basic_burst(input string tag);
    logic [15:0] exp_d [4];
    exp_d[0] = 16'h0011;
    exp_d[1] = 16'h0022;
    exp_d[2] = 16'h0033;
    exp_d[3] = 16'h0044;
    check({tag, "_beats"}, got_q.size(), 4);
    check({tag, "_done_cnt"}, done_cnt, 1);
    if (got_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_data%0d", tag, i), {16'h0, got_q[i]}, {16'h0, exp_d[i]});
        check($sformatf("%s_last%0d", tag, i), {31'h0, got_last_q[i]}, (i == 3) ? 32'd1 : 32'd0);
      end
    end
`ifdef REGFILE_READER_SUM_EN
    check({tag, "_sum"}, {16'h0, sum_at_done}, 32'h00AA);
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[5] = 16'h0011;
    mem[6] = 16'h0022;
    mem[7] = 16'h0033;
    mem[8] = 16'h0044;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_last", {31'h0, out_last}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_raddr", {24'h0, raddr}, 32'd0);
    check("rst_out_data", {16'h0, out_data}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Four-beat burst, out_ready held high
    issue(8'd5, 9'd4);
    check("a_busy", {31'h0, busy}, 32'd1);
    check("a_raddr0", {24'h0, raddr}, 32'd5);
    collect(20, 1'b0);
    check("a_first_vld", first_vld_cyc, 1);
    check("a_done_cyc", done_cyc, 5);
    check("a_idle_after", {31'h0, busy}, 32'd0);
    check_basic_burst("a");

    // Same burst with out_ready toggling 1,0,0,...
    issue(8'd5, 9'd4);
    collect(60, 1'b1);
    check_basic_burst("b");

    // Zero-length command
    issue(8'h10, 9'd0);
    collect(6, 1'b0);
    check("c_no_valid", first_vld_cyc, -1);
    check("c_done_cnt", done_cnt, 1);
    check("c_done_cyc", done_cyc, 0);
    check("c_rdy_low", rdy_low_cnt, 0);

    // Address wrap: 254, 255, 0
    out_ready = 1'b1;
    issue(8'd254, 9'd3);
    check("d_raddr0", {24'h0, raddr}, 32'd254);
    @(posedge clk); #1;
    check("d_raddr1", {24'h0, raddr}, 32'd255);
    check("d_data0", {16'h0, out_data}, 32'h10FE);
    check("d_last0", {31'h0, out_last}, 32'd0);
    @(posedge clk); #1;
    check("d_raddr2", {24'h0, raddr}, 32'd0);
    check("d_data1", {16'h0, out_data}, 32'h10FF);
    @(posedge clk); #1;
    check("d_data2", {16'h0, out_data}, 32'h1000);
    check("d_last2", {31'h0, out_last}, 32'd1);
    @(posedge clk); #1;
    check("d_done", {31'h0, done}, 32'd1);
    check("d_idle", {31'h0, busy}, 32'd0);
    @(posedge clk); #1;

    // Reset after beat 2 of an 8-beat burst
    issue(8'h20, 9'd8);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("e_beat3_pre_rst", {16'h0, out_data}, 32'h1022);
    reset = 1'b0;
    #1;
    check("e_rst_valid", {31'h0, out_valid}, 32'd0);
    check("e_rst_busy", {31'h0, busy}, 32'd0);
    check("e_rst_raddr", {24'h0, raddr}, 32'd0);
    check("e_rst_data", {16'h0, out_data}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    collect(6, 1'b0);
    check("e_no_done", done_cnt, 0);
    check("e_no_valid", first_vld_cyc, -1);

    // First command after reset behaves normally
    issue(8'd5, 9'd4);
    collect(20, 1'b0);
    check("f_first_vld", first_vld_cyc, 1);
    check("f_done_cyc", done_cyc, 5);
    check_basic_burst("f");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the regfile address width (2**DEPTH entries).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning the regfile data width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port cmd_valid  input  1  burst request present.
REQ-006 The block SHALL have port cmd_ready  output  1  request accepted this cycle when high with cmd_valid.
REQ-007 The block SHALL have port cmd_addr  input  DEPTH  first regfile address of the burst.
REQ-008 The block SHALL have port cmd_len  input  DEPTH+1  number of entries to read, 0..2**DEPTH.
REQ-009 The block SHALL have port raddr  output  DEPTH  read address to the regfile.
REQ-010 The block SHALL have port rdata  input  WIDTH  combinational read data from the regfile for raddr.
REQ-011 The block SHALL have port out_valid / out_ready / out_data (WIDTH) / out_last  output/input/output/output  stream of read beats.
REQ-012 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse marking burst completion.

Function
REQ-014 The FSM SHALL have states IDLE, READ, FLUSH; cmd_ready SHALL be 1 only in IDLE.
REQ-015 On cmd_valid&&cmd_ready with cmd_len>0, the block SHALL latch addr=cmd_addr and remaining=cmd_len and enter READ.
REQ-016 On acceptance with cmd_len=0, the block SHALL stay IDLE, emit no beats, and pulse done in the following cycle.
REQ-017 raddr SHALL be driven from the current address register in every state.
REQ-018 In READ, when the output register is empty or out_ready is high, the block SHALL load rdata into out_data, set out_valid, then increment addr and decrement remaining.
REQ-019 Address increment SHALL wrap modulo 2**DEPTH; e.g. 2**DEPTH-1 is followed by 0.
REQ-020 out_last SHALL be 1 on the beat loaded when remaining=1; READ SHALL then transition to FLUSH.
REQ-021 While out_valid && !out_ready, out_data, out_last and raddr SHALL hold, and no new beat SHALL be loaded.
REQ-022 Throughput SHALL be one beat per cycle with out_ready held high.
REQ-023 First out_valid SHALL rise at the rising edge after the acceptance edge.
REQ-024 In FLUSH, the out_valid&&out_ready handshake on the out_last beat SHALL return to IDLE and pulse done in the next cycle.
REQ-025 out_data SHALL reflect regfile contents at the sampling cycle; no write-hazard protection is provided.

Reset
REQ-026 reset low SHALL asynchronously force IDLE with addr=0, remaining=0, out_valid=0, out_data=0, out_last=0, done=0, busy=0, and raddr=0.
REQ-027 Reset mid-burst SHALL drop any pending beat without a done pulse; the first command after reset release SHALL behave normally.

Configuration
REQ-028 With REGFILE_READER_SUM_EN defined, the block SHALL add output sum (WIDTH), the modulo-2**WIDTH sum of all beats handshaked in the burst, cleared on acceptance and stable from the done pulse until the next acceptance.
REQ-029 Without REGFILE_READER_SUM_EN, the sum port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Preload entries 5..8 = 0x0011,0x0022,0x0033,0x0044, cmd_addr=5, cmd_len=4, out_ready=1 -> beats 0x0011..0x0044 on four consecutive cycles, out_last on 0x0044, done one cycle later.
REQ-031 DEPTH=8, cmd_addr=254, cmd_len=3 -> raddr sequence 254, 255, 0; out_last on the addr-0 beat.
REQ-032 Run the REQ-030 burst with out_ready toggled 1,0,0,1,... -> no beat lost or duplicated, and out_data is stable while stalled.
REQ-033 cmd_len=0 -> no out_valid, done pulses exactly once, and cmd_ready stays 1.
REQ-034 Assert reset low for 1 cycle after beat 2 of an 8-beat burst -> out_valid 0 immediately, no done, and the next burst is correct.
REQ-035 With REGFILE_READER_SUM_EN, the REQ-030 burst -> sum=0x00AA at done.
